// File: rtl/fwrisc_mds_unit.sv
// Multi-cycle multiply / divide / shift unit for the fwrisc execute stage.
// Operands arrive over valid/ready; the result is held under back-pressure until it is taken.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_ready=1, waiting for an operation
// BUSY   | one shift / shift-add / restoring-divide iteration per cycle
// DONE   | out_valid=1, result held until out_ready
module fwrisc_mds_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int ENABLE_MUL = 1,
    parameter int ENABLE_DIV = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic [XLEN-1:0] out,
    output logic            out_illegal,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int SW        = $clog2(XLEN);
    localparam int CW        = SW + 1;
    localparam int STEP_LOG2 = $clog2(SHIFT_STEP);

    localparam logic [3:0] OP_SLL    = 4'd0;
    localparam logic [3:0] OP_SRL    = 4'd1;
    localparam logic [3:0] OP_SRA    = 4'd2;
    localparam logic [3:0] OP_MUL    = 4'd3;
    localparam logic [3:0] OP_MULH   = 4'd4;
    localparam logic [3:0] OP_MULHSU = 4'd5;
    localparam logic [3:0] OP_MULHU  = 4'd6;
    localparam logic [3:0] OP_DIV    = 4'd7;
    localparam logic [3:0] OP_DIVU   = 4'd8;
    localparam logic [3:0] OP_REM    = 4'd9;
    localparam logic [3:0] OP_REMU   = 4'd10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [3:0]      op_q;
    logic            neg_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   shamt_q;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] out_q;
    logic            illegal_q;

    // accept-side decode
    logic            is_shift, is_mul, is_div, is_illegal;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [SW-1:0]   amt;
    logic [CW-1:0]   shift_n;
    logic            div_zero, div_ovf;

    always_comb begin
        is_shift   = (op <= OP_SRA);
        is_mul     = (op >= OP_MUL) && (op <= OP_MULHU);
        is_div     = (op >= OP_DIV) && (op <= OP_REMU);
        is_illegal = !(is_shift || (is_mul && (ENABLE_MUL != 0)) || (is_div && (ENABLE_DIV != 0)));
        a_signed   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                     (op == OP_DIV) || (op == OP_REM);
        b_signed   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg      = a_signed && in_a[XLEN-1];
        b_neg      = b_signed && in_b[XLEN-1];
        a_mag      = a_neg ? -in_a : in_a;
        b_mag      = b_neg ? -in_b : in_b;
        amt        = in_b[SW-1:0];
        shift_n    = (CW'(amt) + CW'(SHIFT_STEP - 1)) >> STEP_LOG2;
        div_zero   = (in_b == '0);
        div_ovf    = ((op == OP_DIV) || (op == OP_REM)) && (in_a == MOST_NEG) && (in_b == '1);
    end

    // one iteration of whichever algorithm op_q selects
    logic [CW-1:0]     step_amt;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   hi_nxt, lo_nxt;

    always_comb begin
        step_amt  = (shamt_q >= CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : shamt_q;
        mul_sum   = {1'b0, acc_hi} + {1'b0, opnd_q};
        div_trial = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_trial[XLEN-1:0] - opnd_q;
        hi_nxt    = acc_hi;
        lo_nxt    = acc_lo;
        case (op_q)
            OP_SLL: lo_nxt = acc_lo << step_amt;
            OP_SRL: lo_nxt = acc_lo >> step_amt;
            OP_SRA: lo_nxt = $signed(acc_lo) >>> step_amt;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
                if (acc_lo[0])
                    {hi_nxt, lo_nxt} = {mul_sum, acc_lo[XLEN-1:1]};
                else
                    {hi_nxt, lo_nxt} = {1'b0, acc_hi, acc_lo[XLEN-1:1]};
            end
            default: begin
                if (div_trial >= {1'b0, opnd_q}) begin
                    hi_nxt = div_diff;
                    lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
                end else begin
                    hi_nxt = div_trial[XLEN-1:0];
                    lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
                end
            end
        endcase
    end

    // final result, formed from the last iteration's outputs
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, result;

    always_comb begin
        prod_s = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        quot_s = neg_q ? -lo_nxt : lo_nxt;
        rem_s  = neg_q ? -hi_nxt : hi_nxt;
        case (op_q)
            OP_SLL, OP_SRL, OP_SRA:        result = lo_nxt;
            OP_MUL:                        result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               result = quot_s;
            default:                       result = rem_s;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            count_q   <= '0;
            shamt_q   <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd_q    <= '0;
            out_q     <= '0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            state   <= S_IDLE;
            count_q <= '0;
            shamt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q      <= op;
                        neg_q     <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
                        illegal_q <= 1'b0;
                        if (is_illegal) begin
                            out_q     <= '0;
                            illegal_q <= 1'b1;
                            state     <= S_DONE;
                        end else if (is_shift) begin
                            acc_lo  <= in_a;
                            shamt_q <= CW'(amt);
                            count_q <= shift_n;
                            if (amt == '0) begin
                                out_q <= in_a;
                                state <= S_DONE;
                            end else begin
                                state <= S_BUSY;
                            end
                        end else if (is_div && div_zero) begin
                            out_q <= ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : in_a;
                            state <= S_DONE;
                        end else if (div_ovf) begin
                            out_q <= (op == OP_DIV) ? in_a : '0;
                            state <= S_DONE;
                        end else begin
                            acc_hi  <= '0;
                            acc_lo  <= is_mul ? b_mag : a_mag;
                            opnd_q  <= is_mul ? a_mag : b_mag;
                            count_q <= CW'(XLEN);
                            state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_hi  <= hi_nxt;
                    acc_lo  <= lo_nxt;
                    shamt_q <= shamt_q - step_amt;
                    count_q <= count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        out_q <= result;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign out         = out_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_fwrisc_mds_unit.sv
// Directed bench for fwrisc_mds_unit at XLEN=32, SHIFT_STEP=4.
module tb_fwrisc_mds_unit;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] out;
    logic        out_illegal;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    fwrisc_mds_unit #(.XLEN(32), .SHIFT_STEP(4), .ENABLE_MUL(1), .ENABLE_DIV(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out         (out),
        .out_illegal (out_illegal),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Drives one op; lat counts edges after the accept edge until out_valid is seen.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic ill,
                         output logic rdy_e1, output logic rdy_end);
        op = o; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        rdy_e1 = in_ready;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!out_valid) lat = 999;
        res = out;
        ill = out_illegal;
        if (out_ready) begin
            @(posedge clock); #1;
        end
        rdy_end = in_ready;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (out !== 32'h0 || out_valid !== 1'b0 || out_illegal !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state out=%h valid=%b ill=%b rdy=%b exp 0/0/0/1", out, out_valid, out_illegal, in_ready);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release valid=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic run_table(input string name, input vec_t v[5], input int n);
        int lat; logic [31:0] res; logic ill, r1, re;
        for (int i = 0; i < n; i++) begin
            issue(v[i].op, v[i].a, v[i].b, lat, res, ill, r1, re);
            checks++;
            if (res !== v[i].exp) begin
                failures++;
                $display("FAIL %s[%0d]_result got=%h exp=%h", name, i, res, v[i].exp);
            end
            checks++;
            if (lat != int'(v[i].lat)) begin
                failures++;
                $display("FAIL %s[%0d]_latency got=%0d exp=%0d", name, i, lat, v[i].lat);
            end
            checks++;
            if (ill !== 1'b0 || r1 !== 1'b0 || re !== 1'b1) begin
                failures++;
                $display("FAIL %s[%0d]_flags ill=%b rdy_e1=%b rdy_end=%b exp 0/0/1", name, i, ill, r1, re);
            end
        end
    endtask

    task automatic test_mul;
        vec_t v[5];
        v[0] = '{4'd3, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 8'd32};
        v[1] = '{4'd6, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 8'd32};
        v[2] = '{4'd4, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 8'd32};
        v[3] = '{4'd5, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 8'd32};
        v[4] = '{4'd3, 32'd1234,      32'd5678, 32'd7006652, 8'd32};
        run_table("mul", v, 5);
    endtask

    task automatic test_div;
        vec_t v[5];
        v[0] = '{4'd7,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 8'd32};
        v[1] = '{4'd9,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 8'd32};
        v[2] = '{4'd8,  32'h8000_0000, 32'h3, 32'h2AAA_AAAA, 8'd32};
        v[3] = '{4'd10, 32'h8000_0000, 32'h3, 32'h0000_0002, 8'd32};
        v[4] = '{4'd7,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 8'd32};
        run_table("div", v, 5);
    endtask

    task automatic test_div_special;
        vec_t v[5];
        v[0] = '{4'd7,  32'd5,         32'h0,         32'hFFFF_FFFF, 8'd0};
        v[1] = '{4'd10, 32'd5,         32'h0,         32'd5,         8'd0};
        v[2] = '{4'd7,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd0};
        v[3] = '{4'd9,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         8'd0};
        v[4] = '{4'd8,  32'd9,         32'h0,         32'hFFFF_FFFF, 8'd0};
        run_table("div_special", v, 5);
    endtask

    task automatic test_shift;
        vec_t v[5];
        v[0] = '{4'd2, 32'h8000_0000, 32'd13,   32'hFFFC_0000, 8'd4};
        v[1] = '{4'd0, 32'h1234_5678, 32'd0,    32'h1234_5678, 8'd0};
        v[2] = '{4'd1, 32'hF000_000F, 32'd31,   32'h0000_0001, 8'd8};
        v[3] = '{4'd0, 32'h0000_00A5, 32'h25,   32'h0000_14A0, 8'd2};
        v[4] = '{4'd0, 32'hCAFE_0001, 32'h20,   32'hCAFE_0001, 8'd0};
        run_table("shift", v, 5);
    endtask

    task automatic test_backpressure_illegal;
        int lat; logic [31:0] res; logic ill, r1, re;
        out_ready = 1'b0;
        issue(4'd8, 32'd100, 32'd7, lat, res, ill, r1, re);
        checks++;
        if (res !== 32'd14 || lat != 32) begin
            failures++;
            $display("FAIL bp_divu got=%h lat=%0d exp=%h lat=32", res, lat, 32'd14);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            checks++;
            if (out !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] out=%h valid=%b rdy=%b exp 0000000e/1/0", i, out, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release rdy=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        issue(4'd12, 32'h1234, 32'h5678, lat, res, ill, r1, re);
        checks++;
        if (ill !== 1'b1 || res !== 32'h0 || lat != 0) begin
            failures++;
            $display("FAIL illegal_op ill=%b out=%h lat=%0d exp 1/00000000/0", ill, res, lat);
        end
    endtask

    task automatic test_flush_reset;
        int lat; logic [31:0] res; logic ill, r1, re;
        logic seen;
        op = 4'd3; in_a = 32'd77; in_b = 32'd99; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        // in_valid alongside flush must not start a new op
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle rdy=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_result out_valid_seen=%b exp 0", seen);
        end
        op = 4'd7; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 32'h0) begin
            failures++;
            $display("FAIL async_reset valid=%b rdy=%b out=%h exp 0/1/00000000", out_valid, in_ready, out);
        end
        #1;
        reset = 1'b0;
        issue(4'd3, 32'd3, 32'd4, lat, res, ill, r1, re);
        checks++;
        if (res !== 32'd12 || lat != 32 || ill !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_mul got=%h lat=%0d ill=%b exp 0000000c/32/0", res, lat, ill);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_shift();
        test_backpressure_illegal();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwrisc_mds_unit.md
# fwrisc_mds_unit

Parametrised, handshaked multi-cycle multiply/divide/shift unit for the fwrisc pipelined core: it sits beside the ALU in the execute stage. It implements the full RV32M/RV64M multiply and divide set plus SLL/SRL/SRA at a configurable datapath width, with a configurable shift step. Operands are accepted over a valid/ready handshake, and the result is held under back-pressure until the consumer takes it. Sign handling, divide-by-zero and overflow follow the RISC-V results exactly.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- SHIFT_STEP, 1: bit positions shifted per busy cycle; power of two, 1..XLEN.
- ENABLE_MUL, 1: 0 makes all multiply ops illegal.
- ENABLE_DIV, 1: 0 makes all divide/remainder ops illegal.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  4  0 SLL, 1 SRL, 2 SRA, 3 MUL, 4 MULH, 5 MULHSU, 6 MULHU, 7 DIV, 8 DIVU, 9 REM, 10 REMU, 11-15 illegal.
- in_a  in  XLEN  rs1 operand; shift source.
- in_b  in  XLEN  rs2 operand; shift amount is in_b[$clog2(XLEN)-1:0].
- out  out  XLEN  result.
- out_illegal  out  1  qualifies out; the op was illegal or disabled.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.

## Operation
- Reset values:
  - out=0, out_valid=0, out_illegal=0, in_ready=1.
  - FSM in IDLE; all internal counters 0.
- FSM states:
  - IDLE: in_ready=1. in_valid at an edge captures op/operands, computes N, and moves to BUSY, or to DONE if N=0.
  - BUSY: one iteration per cycle. The iteration counter counts N down; reaching 0 moves to DONE with the result registered.
  - DONE: out_valid=1 with out and out_illegal stable. out_ready moves to IDLE.
- Iteration count N:
  - Shifts: N = ceil(amt/SHIFT_STEP). Each cycle shifts by min(SHIFT_STEP, remaining). SRA fills with bit XLEN-1 of the source.
  - Multiply: N = XLEN. Shift-add runs on operand magnitudes into a 2*XLEN product.
    - Negate the product when the operand signs differ: MUL/MULH use both signs, MULHSU uses in_a only, MULHU uses none.
    - MUL returns product[XLEN-1:0]; the others return product[2XLEN-1:XLEN].
  - Divide/remainder: N = XLEN. Restoring division on magnitudes, one quotient bit per cycle, MSB first.
    - The quotient is negative when the operand signs differ (DIV only).
    - The remainder takes the sign of in_a (REM only).
  - Special cases, N=0:
    - Divisor 0: DIV/DIVU return all-ones; REM/REMU return in_a.
    - Signed overflow (in_a = most negative, in_b = -1): DIV returns in_a; REM returns 0.
  - Illegal or disabled op: N=0, out=0, out_illegal=1.
- flush:
  - Forces IDLE at the next edge and clears out_valid, whatever the state.
  - A flushed result is never presented.
  - in_valid is ignored in the cycle flush is high.
- All arithmetic is modulo 2^XLEN (2^(2XLEN) for the product). Negation is two's complement.

## Timing
- Accept at edge E0 (in_valid && in_ready). out_valid rises at edge E0+N+1.
  - Shift amount 0: result at E0+1.
  - MUL, XLEN=32: result at E0+33.
  - SLL by 13 with SHIFT_STEP=4: N=4, result at E0+5.
- in_ready falls at E0+1. It stays low through BUSY and DONE, and rises the edge after the out_ready transfer. Consecutive ops are therefore at least N+2 cycles apart.
- Under back-pressure (out_ready=0), out and out_illegal hold indefinitely.
- Asserting reset mid-BUSY or in DONE clears state immediately. The first accept is possible at the first edge after reset deasserts.
- flush and out_ready in the same DONE cycle: flush wins, and the consumer must treat the transfer as not taken.
- Inputs op, in_a and in_b are don't-care outside the accept edge.

## Test plan
- Reset, then MUL in_a=0xFFFF_FFFF, in_b=0x2 (XLEN=32) -> out=0xFFFF_FFFE at E0+33. MULHU on the same operands -> 0x1; MULH -> 0xFFFF_FFFF; MULHSU -> 0xFFFF_FFFF.
- DIV in_a=-7, in_b=2 -> 0xFFFF_FFFD (-3); REM -> 0xFFFF_FFFF (-1); DIVU 0x80000000/0x3 -> 0x2AAA_AAAA. All at E0+33.
- Divide-by-zero: DIV 5/0 -> 0xFFFF_FFFF at E0+1. Overflow: DIV 0x8000_0000/-1 -> 0x8000_0000 at E0+1, REM -> 0.
- SHIFT_STEP=4: SRA 0x8000_0000 by 13 -> 0xFFFC_0000 at E0+5. SLL by 0 -> in_a at E0+1. SRL 0xF000_000F by 31 -> 0x1.
- Hold out_ready=0 for 10 cycles after a DIVU. Check out stays stable and in_ready stays 0, then the handshake completes and in_ready=1 on the next edge. Then send op=12 -> out_illegal=1, out=0 at E0+1.
- Assert flush mid-MUL: no out_valid, IDLE on the next edge. Then pulse reset asynchronously mid-DIV: out_valid=0 and in_ready=1 immediately. A following MUL 3*4 returns 12.
